// File: rtl/mips_cpu_bus.sv
// Multicycle MIPS32 subset CPU with one shared Avalon-MM style master port.
// FETCH -> EXEC (-> MEM) per instruction; halts once the PC becomes 0.
module mips_cpu_bus (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'hBFC0_0000;

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
                         OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
                         OP_XORI = 6'h0E, OP_LW = 6'h23, OP_SB = 6'h28,
                         OP_SH = 6'h29, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04,
                         F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR = 6'h08, F_MFHI = 6'h10,
                         F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13, F_MULT = 6'h18,
                         F_MULTU = 6'h19, F_ADDU = 6'h21, F_SUBU = 6'h23, F_AND = 6'h24,
                         F_OR = 6'h25, F_XOR = 6'h26, F_SLT = 6'h2A, F_SLTU = 6'h2B;

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALTED} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d, ir_q, ir_d, ea_q, ea_d, hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0]   br_tgt_q, br_tgt_d;
  logic              br_pend_q, br_pend_d;
  logic [XLEN-1:0]   gpr_q [NREG];
  logic [XLEN-1:0]   gpr_d [NREG];
  logic              active_q, active_d, read_q, read_d, write_q, write_d;
  logic [XLEN-1:0]   address_q, address_d, writedata_q, writedata_d;
  logic [3:0]        be_q, be_d;

  logic [5:0]        opcode, funct;
  logic [4:0]        rs, rt, rd, shamt;
  logic [XLEN-1:0]   rs_val, rt_val, simm, zimm;
  logic [2*XLEN-1:0] prod_s, prod_u;

  logic              wb_en, hi_wr, lo_wr, is_jr, is_load, is_store;
  logic [4:0]        wb_addr;
  logic [XLEN-1:0]   wb_data, hi_new, lo_new;
  logic [3:0]        st_be;
  logic              gpr_we;
  logic [4:0]        gpr_wa;
  logic [XLEN-1:0]   gpr_wd;

  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign shamt  = ir_q[10:6];
  assign funct  = ir_q[5:0];
  assign rs_val = gpr_q[rs];
  assign rt_val = gpr_q[rt];
  assign simm   = {{16{ir_q[15]}}, ir_q[15:0]};
  assign zimm   = {16'd0, ir_q[15:0]};
  // Sign-extending to 64 bits first makes the low 64 product bits the signed result.
  assign prod_s = {{XLEN{rs_val[31]}}, rs_val} * {{XLEN{rt_val[31]}}, rt_val};
  assign prod_u = {XLEN'(0), rs_val} * {XLEN'(0), rt_val};

  // Instruction decode and ALU result.
  always_comb begin
    wb_en    = 1'b0;
    wb_addr  = rd;
    wb_data  = '0;
    hi_wr    = 1'b0;
    lo_wr    = 1'b0;
    hi_new   = '0;
    lo_new   = '0;
    is_jr    = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    st_be    = 4'b1111;
    case (opcode)
      OP_SPECIAL: begin
        wb_en = 1'b1;
        case (funct)
          F_SLL:   wb_data = rt_val << shamt;
          F_SRL:   wb_data = rt_val >> shamt;
          F_SRA:   wb_data = XLEN'($signed(rt_val) >>> shamt);
          F_SLLV:  wb_data = rt_val << rs_val[4:0];
          F_SRLV:  wb_data = rt_val >> rs_val[4:0];
          F_SRAV:  wb_data = XLEN'($signed(rt_val) >>> rs_val[4:0]);
          F_ADDU:  wb_data = rs_val + rt_val;
          F_SUBU:  wb_data = rs_val - rt_val;
          F_AND:   wb_data = rs_val & rt_val;
          F_OR:    wb_data = rs_val | rt_val;
          F_XOR:   wb_data = rs_val ^ rt_val;
          F_SLT:   wb_data = {31'd0, $signed(rs_val) < $signed(rt_val)};
          F_SLTU:  wb_data = {31'd0, rs_val < rt_val};
          F_MFHI:  wb_data = hi_q;
          F_MFLO:  wb_data = lo_q;
          F_MTHI:  begin wb_en = 1'b0; hi_wr = 1'b1; hi_new = rs_val; end
          F_MTLO:  begin wb_en = 1'b0; lo_wr = 1'b1; lo_new = rs_val; end
          F_MULT:  begin wb_en = 1'b0; hi_wr = 1'b1; lo_wr = 1'b1; {hi_new, lo_new} = prod_s; end
          F_MULTU: begin wb_en = 1'b0; hi_wr = 1'b1; lo_wr = 1'b1; {hi_new, lo_new} = prod_u; end
          F_JR:    begin wb_en = 1'b0; is_jr = 1'b1; end
          default: wb_en = 1'b0;
        endcase
      end
      OP_ADDIU: begin wb_en = 1'b1; wb_addr = rt; wb_data = rs_val + simm; end
      OP_SLTI:  begin wb_en = 1'b1; wb_addr = rt; wb_data = {31'd0, $signed(rs_val) < $signed(simm)}; end
      OP_SLTIU: begin wb_en = 1'b1; wb_addr = rt; wb_data = {31'd0, rs_val < simm}; end
      OP_ANDI:  begin wb_en = 1'b1; wb_addr = rt; wb_data = rs_val & zimm; end
      OP_ORI:   begin wb_en = 1'b1; wb_addr = rt; wb_data = rs_val | zimm; end
      OP_XORI:  begin wb_en = 1'b1; wb_addr = rt; wb_data = rs_val ^ zimm; end
      OP_LW:    is_load = 1'b1;
      OP_SB:    begin is_store = 1'b1; st_be = 4'b0001; end
      OP_SH:    begin is_store = 1'b1; st_be = 4'b0011; end
      OP_SW:    is_store = 1'b1;
      default:  ;
    endcase
  end

  // Next-state, write-back and registered bus request for the state being entered.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    ea_d        = ea_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    br_pend_d   = br_pend_q;
    br_tgt_d    = br_tgt_q;
    gpr_d       = gpr_q;
    gpr_we      = 1'b0;
    gpr_wa      = wb_addr;
    gpr_wd      = wb_data;
    active_d    = 1'b0;
    read_d      = 1'b0;
    write_d     = 1'b0;
    address_d   = '0;
    writedata_d = '0;
    be_d        = '0;
    case (state_q)
      FETCH: begin
        if (read_q && !waitrequest) begin
          ir_d    = readdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // A pending JR target takes effect once its delay slot executes.
        pc_d      = br_pend_q ? br_tgt_q : pc_q + 32'd4;
        br_pend_d = is_jr;
        br_tgt_d  = is_jr ? rs_val : br_tgt_q;
        if (is_load || is_store) begin
          ea_d    = rs_val + simm;
          state_d = MEM;
        end else begin
          gpr_we  = wb_en;
          if (hi_wr) hi_d = hi_new;
          if (lo_wr) lo_d = lo_new;
          state_d = (pc_d == '0) ? HALTED : FETCH;
        end
      end
      MEM: begin
        if (!waitrequest) begin
          gpr_we  = is_load;
          gpr_wa  = rt;
          gpr_wd  = readdata;
          state_d = (pc_q == '0) ? HALTED : FETCH;
        end
      end
      HALTED:  ;
      default: state_d = FETCH;
    endcase
    if (gpr_we && gpr_wa != 5'd0) gpr_d[gpr_wa] = gpr_wd;

    active_d = (state_d != HALTED);
    case (state_d)
      FETCH: begin
        read_d    = 1'b1;
        address_d = pc_d;
        be_d      = 4'b1111;
      end
      MEM: begin
        address_d = ea_d;
        if (is_load) begin
          read_d = 1'b1;
          be_d   = 4'b1111;
        end else begin
          write_d     = 1'b1;
          writedata_d = rt_val;
          be_d        = st_be;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      ea_q        <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      br_pend_q   <= 1'b0;
      br_tgt_q    <= '0;
      for (int i = 0; i < NREG; i++) gpr_q[i] <= '0;
      active_q    <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      address_q   <= '0;
      writedata_q <= '0;
      be_q        <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      ea_q        <= ea_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      br_pend_q   <= br_pend_d;
      br_tgt_q    <= br_tgt_d;
      gpr_q       <= gpr_d;
      active_q    <= active_d;
      read_q      <= read_d;
      write_q     <= write_d;
      address_q   <= address_d;
      writedata_q <= writedata_d;
      be_q        <= be_d;
    end
  end

  assign active      = active_q;
  assign read        = read_q;
  assign write       = write_q;
  assign address     = address_q;
  assign writedata   = writedata_q;
  assign byteenable  = be_q;
  assign register_v0 = gpr_q[2];
endmodule

// File: tb/tb_mips_cpu_bus.sv
// Scoreboarded bench for mips_cpu_bus: runs a program from the reset vector and
// compares every store cycle against expected {address, data, byteenable}.
module tb_mips_cpu_bus;
  localparam logic [31:0] RESET_PC    = 32'hBFC0_0000;
  localparam logic [31:0] STALL_FETCH = RESET_PC + 32'd8;
  localparam logic [31:0] STALL_STORE = 32'd200;
  localparam int MAX_CYCLES = 5000;

  localparam int OP_ADDIU = 'h09, OP_SLTI = 'h0A, OP_SLTIU = 'h0B, OP_ANDI = 'h0C,
                 OP_ORI = 'h0D, OP_XORI = 'h0E, OP_LW = 'h23, OP_SB = 'h28,
                 OP_SH = 'h29, OP_SW = 'h2B;
  localparam int F_SLL = 'h00, F_SRL = 'h02, F_SRA = 'h03, F_SLLV = 'h04, F_SRLV = 'h06,
                 F_SRAV = 'h07, F_JR = 'h08, F_MFHI = 'h10, F_MTHI = 'h11, F_MFLO = 'h12,
                 F_MTLO = 'h13, F_MULT = 'h18, F_MULTU = 'h19, F_ADDU = 'h21,
                 F_SUBU = 'h23, F_AND = 'h24, F_OR = 'h25, F_XOR = 'h26, F_SLT = 'h2A,
                 F_SLTU = 'h2B;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        active, write, read, waitrequest;
  logic [31:0] register_v0, address, writedata, readdata;
  logic [3:0]  byteenable;

  mips_cpu_bus dut (
    .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
    .address(address), .write(write), .read(read), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_mis = 0;
  bit          bus_en = 1'b1;
  logic [31:0] prog[$];
  logic [67:0] sb[$];
  bit   [31:0] mem [bit [31:0]];
  int          sa = 228;

  task automatic check_eq(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_op(input int rs, input int rt, input int rd,
                                       input int sh, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] i_op(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic emit(input logic [31:0] w);
    prog.push_back(w);
  endtask

  task automatic st(input int op, input int base, input int rt, input int off,
                    input logic [31:0] ea, input logic [31:0] data, input logic [3:0] be);
    emit(i_op(op, base, rt, off));
    sb.push_back({ea, data, be});
  endtask

  // Executes w (destination $3) and stores $3 to the next probe slot.
  task automatic probe(input logic [31:0] w, input logic [31:0] exp);
    emit(w);
    st(OP_SW, 0, 3, sa, 32'(sa), exp, 4'hF);
    sa += 4;
  endtask

  task automatic build_program();
    int i;
    emit(i_op(OP_LW, 0, 1, 100));
    emit(r_op(1, 0, 0, 0, F_MTHI));
    emit(r_op(0, 0, 4, 0, F_MFHI));
    st(OP_SW, 0, 4, 200, 200, 123, 4'hF);
    emit(i_op(OP_ADDIU, 0, 1, 404));
    emit(r_op(1, 0, 0, 0, F_MTLO));
    emit(r_op(0, 0, 5, 0, F_MFLO));
    st(OP_SW, 0, 5, 204, 204, 404, 4'hF);
    emit(i_op(OP_ADDIU, 0, 1, 3));
    emit(i_op(OP_ADDIU, 0, 2, 4));
    emit(r_op(1, 2, 0, 0, F_MULT));
    emit(r_op(0, 0, 3, 0, F_MFLO));
    st(OP_SW, 0, 3, 208, 208, 12, 4'hF);
    emit(r_op(1, 2, 0, 0, F_MULTU));
    emit(r_op(0, 0, 3, 0, F_MFLO));
    st(OP_SW, 0, 3, 212, 212, 12, 4'hF);
    emit(i_op(OP_ADDIU, 0, 6, -3));
    emit(r_op(6, 2, 0, 0, F_MULT));
    emit(r_op(0, 0, 3, 0, F_MFHI));
    st(OP_SW, 0, 3, 216, 216, 32'hFFFF_FFFF, 4'hF);
    emit(r_op(0, 0, 3, 0, F_MFLO));
    st(OP_SW, 0, 3, 220, 220, 32'hFFFF_FFF4, 4'hF);
    emit(r_op(6, 2, 0, 0, F_MULTU));
    emit(r_op(0, 0, 3, 0, F_MFHI));
    st(OP_SW, 0, 3, 224, 224, 3, 4'hF);
    emit(i_op(OP_ADDIU, 0, 1, 9));
    emit(i_op(OP_ADDIU, 0, 2, 5));
    probe(r_op(1, 2, 3, 0, F_OR), 13);
    probe(i_op(OP_ORI, 1, 3, 5), 13);
    probe(r_op(1, 2, 3, 0, F_XOR), 12);
    probe(i_op(OP_XORI, 1, 3, 5), 12);
    probe(r_op(1, 2, 3, 0, F_SUBU), 4);
    probe(r_op(1, 2, 3, 0, F_ADDU), 14);
    probe(r_op(1, 2, 3, 0, F_AND), 1);
    probe(i_op(OP_ANDI, 1, 3, 5), 1);
    probe(r_op(0, 1, 3, 2, F_SLL), 36);
    probe(r_op(1, 2, 3, 0, F_SLT), 0);
    probe(i_op(OP_SLTI, 1, 3, 15), 1);
    probe(i_op(OP_SLTIU, 1, 3, 15), 1);
    probe(r_op(1, 2, 3, 0, F_SLTU), 0);
    probe(r_op(6, 1, 3, 0, F_SLT), 1);
    probe(r_op(6, 1, 3, 0, F_SLTU), 0);
    probe(i_op(OP_SLTI, 6, 3, 1), 1);
    probe(i_op(OP_SLTIU, 6, 3, 1), 0);
    probe(i_op(OP_SLTIU, 1, 3, -1), 1);
    probe(r_op(0, 1, 3, 3, F_SRA), 1);
    probe(r_op(0, 1, 3, 3, F_SRL), 1);
    probe(r_op(0, 6, 3, 1, F_SRA), 32'hFFFF_FFFE);
    probe(r_op(0, 6, 3, 1, F_SRL), 32'h7FFF_FFFE);
    probe(r_op(2, 1, 3, 0, F_SRAV), 0);
    probe(r_op(2, 1, 3, 0, F_SRLV), 0);
    probe(r_op(2, 1, 3, 0, F_SLLV), 288);
    probe(r_op(1, 6, 3, 0, F_SRAV), 32'hFFFF_FFFF);
    probe(i_op(OP_ADDIU, 1, 3, -1), 8);
    probe(i_op(OP_XORI, 6, 3, 'hFFFF), 32'hFFFF_0002);
    st(OP_SB, 0, 1, 206, 206, 9, 4'b0001);
    st(OP_SH, 0, 1, 207, 207, 9, 4'b0011);
    emit(i_op(OP_ADDIU, 0, 0, 5));
    st(OP_SW, 0, 0, 300, 300, 0, 4'hF);
    emit(32'hFC00_0000);
    st(OP_SW, 0, 1, 304, 304, 9, 4'hF);
    emit(i_op(OP_ADDIU, 0, 9, 300));
    st(OP_SW, 9, 1, 8, 308, 9, 4'hF);
    // Forward JR: the delay slot runs, the following store is skipped.
    emit(i_op(OP_ADDIU, 0, 7, 'hBFC0));
    emit(r_op(0, 7, 7, 16, F_SLL));
    i = prog.size();
    emit(i_op(OP_ORI, 7, 7, (i + 4) * 4));
    emit(r_op(7, 0, 0, 0, F_JR));
    emit(i_op(OP_ADDIU, 0, 8, 55));
    emit(i_op(OP_SW, 0, 0, 500));
    st(OP_SW, 0, 8, 504, 504, 55, 4'hF);
    emit(i_op(OP_ADDIU, 0, 2, 'h77));
    emit(r_op(0, 0, 0, 0, F_JR));
    st(OP_SW, 0, 2, 400, 400, 32'h77, 4'hF);
    emit(i_op(OP_SW, 0, 2, 404));
  endtask

  // Memory slave: stalls one fetch and one store for 3 cycles, scoreboards writes.
  initial begin
    logic [69:0] cur, snap;
    logic [67:0] e;
    bit          in_xfer = 1'b0;
    bit          fetch_stalled = 1'b0;
    bit          store_stalled = 1'b0;
    int          wait_left = 0;
    waitrequest = 1'b0;
    readdata    = '0;
    forever begin
      @(negedge clk);
      if (!bus_en) begin
        waitrequest = 1'b1;
      end else if (read || write) begin
        cur = {read, write, byteenable, address, writedata};
        if (!in_xfer) begin
          in_xfer   = 1'b1;
          snap      = cur;
          wait_left = 0;
          if (read && address == STALL_FETCH && !fetch_stalled) begin
            wait_left = 3; fetch_stalled = 1'b1;
          end
          if (write && address == STALL_STORE && !store_stalled) begin
            wait_left = 3; store_stalled = 1'b1;
          end
        end else begin
          check_eq("hold", cur, snap);
        end
        if (wait_left > 0) begin
          waitrequest = 1'b1;
          wait_left--;
        end else begin
          waitrequest = 1'b0;
          in_xfer     = 1'b0;
          if (read) begin
            readdata = mem.exists(address) ? mem[address] : 32'd0;
          end else begin
            check_eq("rw_excl", 70'(read), 70'(0));
            check_eq("sb_pending", 70'(sb.size() != 0), 70'(1));
            if (sb.size() != 0) begin
              e = sb.pop_front();
              check_eq($sformatf("st_addr@%0d", e[67:36]), 70'(address), 70'(e[67:36]));
              check_eq($sformatf("st_data@%0d", e[67:36]), 70'(writedata), 70'(e[35:4]));
              check_eq($sformatf("st_be@%0d", e[67:36]), 70'(byteenable), 70'(e[3:0]));
            end
            if (byteenable == 4'hF) mem[address] = writedata;
          end
        end
      end else begin
        waitrequest = 1'b0;
        in_xfer     = 1'b0;
      end
    end
  end

  initial begin
    int cyc;
    build_program();
    foreach (prog[i]) mem[RESET_PC + 32'(4 * i)] = prog[i];
    mem[32'd100] = 32'd123;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_active", 70'(active), 70'(0));
    check_eq("rst_bus", {read, write, byteenable, address, writedata}, 70'(0));
    check_eq("rst_v0", 70'(register_v0), 70'(0));

    reset = 1'b1;
    @(negedge clk);
    check_eq("first_fetch", 70'({read, write, byteenable, address}),
             70'({1'b1, 1'b0, 4'hF, RESET_PC}));
    check_eq("first_active", 70'(active), 70'(1));

    cyc = 0;
    while (active && cyc < MAX_CYCLES) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("halt_reached", 70'(active), 70'(0));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("halted_idle", 70'({read, write, active}), 70'(0));
    end
    check_eq("final_v0", 70'(register_v0), 70'(32'h77));
    check_eq("sb_drained", 70'(sb.size()), 70'(0));

    // Reset after halt, then abandon a stalled fetch with a second reset.
    bus_en = 1'b0;
    reset  = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rerst_v0", 70'(register_v0), 70'(0));
    check_eq("rerst_idle", 70'({read, write, active}), 70'(0));
    reset = 1'b1;
    @(negedge clk);
    check_eq("refetch", 70'({read, address}), 70'({1'b1, RESET_PC}));
    @(negedge clk);
    check_eq("refetch_stall", 70'({read, address}), 70'({1'b1, RESET_PC}));
    reset = 1'b0;
    @(negedge clk);
    check_eq("abandon", 70'({read, write, active}), 70'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
